// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for mod_n_updown_counter: the master drives commands,
// and the counter (slave) returns its count and the status pulses.
interface mod_n_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output count, tc, wrap, load_err
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clear, clamped load, cascade tc and wrap/load_err pulses.
// Define MOD_N_CNT_SAT_EN to saturate at the range ends instead of wrapping.
module mod_n_updown_counter #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mod_n_updown_counter_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_cfg
    $error("mod_n_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic             at_top, at_bot;

  assign at_top = (cnt_q == MAXV);
  assign at_bot = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      // Out-of-range loads clamp to the top of the range and flag the error.
      if (bus.load_val > MAXV) begin
        cnt_d  = MAXV;
        lerr_d = 1'b1;
      end else begin
        cnt_d = bus.load_val;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_top) begin
`ifdef MOD_N_CNT_SAT_EN
          cnt_d  = MAXV;
`else
          cnt_d  = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
`ifdef MOD_N_CNT_SAT_EN
          cnt_d  = '0;
`else
          cnt_d  = MAXV;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  // Combinational so a cascaded stage steps on the same edge this one wraps.
  assign bus.tc       = bus.en & ((bus.up_dn & at_top) | (~bus.up_dn & at_bot));
  assign bus.count    = cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = lerr_q;

endmodule
